// File: rtl/conv4x4_mac.sv
// Two-stage pipelined 4x4 signed dot product: 16 registered products, then a
// balanced adder tree registered into conv_out (2-cycle latency, 1 result/clock).
module conv4x4_mac #(
  parameter int DATA_W = 8,
  parameter int OUT_W  = 25
) (
  input  logic signed [DATA_W-1:0] data_00,
  input  logic signed [DATA_W-1:0] data_01,
  input  logic signed [DATA_W-1:0] data_02,
  input  logic signed [DATA_W-1:0] data_03,
  input  logic signed [DATA_W-1:0] data_10,
  input  logic signed [DATA_W-1:0] data_11,
  input  logic signed [DATA_W-1:0] data_12,
  input  logic signed [DATA_W-1:0] data_13,
  input  logic signed [DATA_W-1:0] data_20,
  input  logic signed [DATA_W-1:0] data_21,
  input  logic signed [DATA_W-1:0] data_22,
  input  logic signed [DATA_W-1:0] data_23,
  input  logic signed [DATA_W-1:0] data_30,
  input  logic signed [DATA_W-1:0] data_31,
  input  logic signed [DATA_W-1:0] data_32,
  input  logic signed [DATA_W-1:0] data_33,
  input  logic signed [DATA_W-1:0] kernel_00,
  input  logic signed [DATA_W-1:0] kernel_01,
  input  logic signed [DATA_W-1:0] kernel_02,
  input  logic signed [DATA_W-1:0] kernel_03,
  input  logic signed [DATA_W-1:0] kernel_10,
  input  logic signed [DATA_W-1:0] kernel_11,
  input  logic signed [DATA_W-1:0] kernel_12,
  input  logic signed [DATA_W-1:0] kernel_13,
  input  logic signed [DATA_W-1:0] kernel_20,
  input  logic signed [DATA_W-1:0] kernel_21,
  input  logic signed [DATA_W-1:0] kernel_22,
  input  logic signed [DATA_W-1:0] kernel_23,
  input  logic signed [DATA_W-1:0] kernel_30,
  input  logic signed [DATA_W-1:0] kernel_31,
  input  logic signed [DATA_W-1:0] kernel_32,
  input  logic signed [DATA_W-1:0] kernel_33,
  input  logic                     clk,
  input  logic                     rst_n,
  output logic signed [OUT_W-1:0]  conv_out
);

  localparam int P_W = 2 * DATA_W;

  logic signed [DATA_W-1:0] data_arr   [16];
  logic signed [DATA_W-1:0] kernel_arr [16];
  logic signed [P_W-1:0]    prod_reg   [16];
  logic signed [P_W:0]      lvl1       [8];
  logic signed [P_W+1:0]    lvl2       [4];
  logic signed [P_W+2:0]    lvl3       [2];
  logic signed [P_W+3:0]    tree_sum;

  // Index r*4+c: pairing is purely positional.
  assign data_arr = '{data_00, data_01, data_02, data_03,
                      data_10, data_11, data_12, data_13,
                      data_20, data_21, data_22, data_23,
                      data_30, data_31, data_32, data_33};
  assign kernel_arr = '{kernel_00, kernel_01, kernel_02, kernel_03,
                        kernel_10, kernel_11, kernel_12, kernel_13,
                        kernel_20, kernel_21, kernel_22, kernel_23,
                        kernel_30, kernel_31, kernel_32, kernel_33};

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_mul
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prod_reg[gi] <= '0;
        else        prod_reg[gi] <= P_W'(data_arr[gi]) * P_W'(kernel_arr[gi]);
      end
    end

    // Each tree level grows one bit, so no level can overflow.
    for (gi = 0; gi < 8; gi++) begin : g_lvl1
      assign lvl1[gi] = (P_W+1)'(prod_reg[2*gi]) + (P_W+1)'(prod_reg[2*gi+1]);
    end
    for (gi = 0; gi < 4; gi++) begin : g_lvl2
      assign lvl2[gi] = (P_W+2)'(lvl1[2*gi]) + (P_W+2)'(lvl1[2*gi+1]);
    end
    for (gi = 0; gi < 2; gi++) begin : g_lvl3
      assign lvl3[gi] = (P_W+3)'(lvl2[2*gi]) + (P_W+3)'(lvl2[2*gi+1]);
    end
  endgenerate

  assign tree_sum = (P_W+4)'(lvl3[0]) + (P_W+4)'(lvl3[1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) conv_out <= '0;
    else        conv_out <= OUT_W'(tree_sum);
  end

endmodule

// File: tb/tb_conv4x4_mac.sv
// Directed and streaming checks for conv4x4_mac: reset behaviour, known sums,
// extremes, positional pairing and back-to-back pipelining.
module tb_conv4x4_mac;

  logic clk;
  logic rst_n;
  logic signed [7:0]  d [16];
  logic signed [7:0]  k [16];
  logic signed [24:0] conv_out;

  int n_vec = 0;
  int n_bad = 0;
  int exp_q [1000];

  conv4x4_mac #(.DATA_W(8), .OUT_W(25)) dut (
    .data_00(d[0]),  .data_01(d[1]),  .data_02(d[2]),  .data_03(d[3]),
    .data_10(d[4]),  .data_11(d[5]),  .data_12(d[6]),  .data_13(d[7]),
    .data_20(d[8]),  .data_21(d[9]),  .data_22(d[10]), .data_23(d[11]),
    .data_30(d[12]), .data_31(d[13]), .data_32(d[14]), .data_33(d[15]),
    .kernel_00(k[0]),  .kernel_01(k[1]),  .kernel_02(k[2]),  .kernel_03(k[3]),
    .kernel_10(k[4]),  .kernel_11(k[5]),  .kernel_12(k[6]),  .kernel_13(k[7]),
    .kernel_20(k[8]),  .kernel_21(k[9]),  .kernel_22(k[10]), .kernel_23(k[11]),
    .kernel_30(k[12]), .kernel_31(k[13]), .kernel_32(k[14]), .kernel_33(k[15]),
    .clk(clk),
    .rst_n(rst_n),
    .conv_out(conv_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] got,
                     input logic signed [31:0] exp_v);
    n_vec++;
    if (got !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp_v);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic fill(input logic signed [7:0] dv, input logic signed [7:0] kv);
    for (int i = 0; i < 16; i++) begin
      d[i] = dv;
      k[i] = kv;
    end
  endtask

  // Inputs are set just after an edge; result is checked just after the second edge.
  task automatic settle2;
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  function automatic int dot();
    int s = 0;
    for (int i = 0; i < 16; i++) s += int'(d[i]) * int'(k[i]);
    return s;
  endfunction

  initial begin
    rst_n = 1'b1;
    fill(8'sd1, 8'sd1);

    // Asynchronous reset before any clock edge.
    #1 rst_n = 1'b0;
    #2 chk("rst_async", conv_out, 0);
    repeat (3) @(posedge clk);
    #1 chk("rst_held", conv_out, 0);

    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1 chk("rel_edge1", conv_out, 0);
    @(posedge clk); #1 chk("rel_ones", conv_out, 16);

    // Identity kernel.
    fill(8'sd7, 8'sd0);
    d[0] = -8'sd5;
    k[0] = 8'sd1;
    settle2();
    chk("identity", conv_out, -5);
    chk("identity_raw", {7'b0, conv_out}, 32'h01FF_FFFB);

    fill(8'sd3, -8'sd2);
    settle2(); chk("three_neg2", conv_out, -96);
    fill(-8'sd128, -8'sd128);
    settle2(); chk("max_pos", conv_out, 262144);
    fill(-8'sd128, 8'sd127);
    settle2(); chk("max_neg", conv_out, -260096);
    fill(8'sd127, 8'sd127);
    settle2(); chk("p127_sq", conv_out, 258064);

    // Positional sweep: data = 4r+c, one-hot kernel.
    for (int p = 0; p < 16; p++) begin
      for (int i = 0; i < 16; i++) begin
        d[i] = 8'(i);
        k[i] = (i == p) ? 8'sd1 : 8'sd0;
      end
      settle2();
      chk($sformatf("pos_%0d%0d", p / 4, p % 4), conv_out, p);
    end

    // Back-to-back stream: new vector every clock, result two edges later.
    for (int n = 0; n < 1002; n++) begin
      if (n >= 2) chk($sformatf("pipe_%0d", n - 2), conv_out, exp_q[n-2]);
      if (n < 1000) begin
        for (int i = 0; i < 16; i++) begin
          d[i] = 8'($urandom_range(0, 255));
          k[i] = 8'($urandom_range(0, 255));
        end
        exp_q[n] = dot();
      end
      @(posedge clk); #1;
    end

    // Reset asserted mid-stream discards in-flight results.
    fill(8'sd1, 8'sd1);
    settle2(); chk("pre_rst", conv_out, 16);
    fill(8'sd2, 8'sd5);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("mid_rst_async", conv_out, 0);
    @(posedge clk); #1 chk("mid_rst_held", conv_out, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1 chk("mid_rel_edge1", conv_out, 0);
    @(posedge clk); #1 chk("mid_rel_sum", conv_out, 160);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/conv4x4_mac.md
# conv4x4_mac

Pipelined 4×4 signed multiply-accumulate: one 4×4 window of 8-bit feature-map data is multiplied element-wise by a 4×4 8-bit kernel, and the 16 products are summed into one 25-bit signed result. The CONV top level uses two instances: one for the window at the current column and one for the window shifted by one column. Each instance produces one partial-sum value per channel per clock, which the top level accumulates across channels.

## Interface
- `DATA_W`, default 8: width of each data and kernel element, two's-complement signed.
- `OUT_W`, default 25: width of the result, signed; must be ≥ 2·DATA_W+4.
- `clk`, input, 1: sole clock, rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `data_00`…`data_03`, input, DATA_W each: window row 0, columns 0–3.
- `data_10`…`data_13`, input, DATA_W each: window row 1.
- `data_20`…`data_23`, input, DATA_W each: window row 2.
- `data_30`…`data_33`, input, DATA_W each: window row 3.
- `kernel_00`…`kernel_33`, input, DATA_W each: kernel elements, same row/column indexing as data.
- `conv_out`, output, OUT_W: registered result, signed.
- Port order is fixed: 16 data inputs (row-major), 16 kernel inputs (row-major), `clk`, `rst_n`, `conv_out`.

## Operation
- Result is the sum over r,c ∈ 0..3 of data_rc × kernel_rc. All operands are signed.
- Products are full precision, 2·DATA_W bits (16 bits by default), signed.
- Sum uses a balanced adder tree: 16→8→4→2→1. Each level widens by 1 bit, giving 2·DATA_W+4 bits (20 bits by default). The tree output is sign-extended to OUT_W.
- No overflow is possible at the defaults. The extremes are:
  - +262144 when all 16 pairs are (−128)×(−128).
  - −260096 when all 16 pairs are (−128)×(127).
- No saturation and no rounding are applied.
- There is no enable and no valid signal. The block computes on every clock, and the caller aligns its samples by the fixed latency.
- Element pairing is positional only: data_rc always pairs with kernel_rc. The block has no knowledge of channel, row or kernel indices.

## Timing
- Stage 1: on each rising `clk`, all 16 products are registered from the input values present before that edge.
- Stage 2: on the next rising edge, the adder-tree sum of the stage-1 registers is registered into `conv_out`.
- Latency: inputs sampled at edge N appear on `conv_out` right after edge N+1, i.e. 2-cycle latency.
- Throughput: one result per clock, fully pipelined, no stalls.
- Reset, `rst_n` = 0:
  - Clears the product registers and `conv_out` to 0 immediately, independent of `clk`.
  - Reset asserted mid-stream discards all in-flight results.
  - After `rst_n` rises, the first valid output reflects inputs sampled at the first edge after release; it appears one edge later.
  - Until then `conv_out` reads 0.
- Inputs are changed back-to-back every cycle without hazard. Each result depends only on its own sampling edge.

## Test plan
- Reset: drive `rst_n` = 0 with nonzero inputs, holding or not toggling `clk` → `conv_out` = 0 at once. Release reset with inputs held → `conv_out` = 0 for one edge, then the correct sum.
- Identity: all kernel = 0 except kernel_00 = 1, data_00 = −5, other data = 7 → `conv_out` = −5 (25-bit sign-extended 0x1FFFFFB), two edges after applying.
- All ones: all data = 1, all kernel = 1 → 16. All data = 3, all kernel = −2 → −96.
- Extremes:
  - All data = −128, all kernel = −128 → 262144.
  - All data = −128, all kernel = 127 → −260096.
  - All data = 127, all kernel = 127 → 258064.
- Pipelining: apply a new random vector every cycle for 1000 cycles → each `conv_out` equals the software dot product of the vector applied two edges earlier, with no bubbles.
- Positional check: data_rc = 4r+c, kernel_rc = 1 for a single (r,c) at a time, swept over all 16 positions → `conv_out` = 4r+c for each.
